// File: rtl/bram_pkg.sv
// Shared constants and write-mode decoding for the single-port block RAM family.
package bram_pkg;

  localparam int BRAM_DATA_WIDTH = 16;
  localparam int BRAM_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    WM_WRITE_FIRST,
    WM_READ_FIRST,
    WM_NO_CHANGE,
    WM_INVALID
  } wmode_e;

  // Maps the user-facing mode string to the enum; unknown strings become WM_INVALID.
  function automatic wmode_e wmode_decode(input string mode);
    if (mode == "WRITE_FIRST") return WM_WRITE_FIRST;
    if (mode == "READ_FIRST")  return WM_READ_FIRST;
    if (mode == "NO_CHANGE")   return WM_NO_CHANGE;
    return WM_INVALID;
  endfunction

endpackage

// File: rtl/bram_out_reg.sv
// Optional second read-data pipeline stage; async clear, loads every cycle.
module bram_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/bram_sp.sv
// Single-port synchronous block RAM with selectable write mode and optional
// second output register. Reset clears the output path only, never the array.
module bram_sp
  import bram_pkg::*;
#(
  parameter int                    DATA_WIDTH = BRAM_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = BRAM_ADDR_WIDTH,
  parameter string                 WRITE_MODE = "WRITE_FIRST",
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta
);

  localparam int     DEPTH = 1 << ADDR_WIDTH;
  localparam wmode_e WMODE = wmode_decode(WRITE_MODE);

  if (WMODE == WM_INVALID) begin : g_bad_mode
    $error("bram_sp: unsupported WRITE_MODE \"%s\"", WRITE_MODE);
  end

  // Assert asynchronously, release synchronously, so the output flops never
  // see a reset edge close to clka.
  logic [1:0] rst_sync;
  logic       rst_n_i;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_i = rst_sync[1];

  // No reset on the array so synthesis can map it onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
  end

  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clka or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dout_q <= '0;
    end else if (ena) begin
      if (!wea) begin
        dout_q <= mem[addra];
      end else begin
        case (WMODE)
          WM_WRITE_FIRST: dout_q <= dina;
          WM_READ_FIRST:  dout_q <= mem[addra];
          default:        dout_q <= dout_q;
        endcase
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    bram_out_reg #(
      .WIDTH (DATA_WIDTH)
    ) u_out_reg (
      .clk   (clka),
      .rst_n (rst_n_i),
      .d     (dout_q),
      .q     (douta)
    );
  end else begin : g_no_out_reg
    assign douta = dout_q;
  end

endmodule

// File: tb/tb_bram_sp.sv
// Scoreboard bench: four bram_sp variants share one stimulus stream and are
// compared every cycle against a behavioural model of the memory.
module tb_bram_sp;

  logic        clk = 1'b0;
  logic        rsta_n = 1'b1;
  logic        ena = 1'b0;
  logic        wea = 1'b0;
  logic [3:0]  addra = '0;
  logic [15:0] dina = '0;
  logic [15:0] dout_wf, dout_rf, dout_nc, dout_p2;

  always #5 clk = ~clk;

  bram_sp #(.WRITE_MODE("WRITE_FIRST"), .OUT_REG(0)) u_wf (
    .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_wf));
  bram_sp #(.WRITE_MODE("READ_FIRST"), .OUT_REG(0)) u_rf (
    .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_rf));
  bram_sp #(.WRITE_MODE("NO_CHANGE"), .OUT_REG(0)) u_nc (
    .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_nc));
  bram_sp #(.WRITE_MODE("WRITE_FIRST"), .OUT_REG(1)) u_p2 (
    .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_p2));

  typedef struct {
    string       tag;
    logic [15:0] wf, rf, nc, p2;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Behavioural model state
  logic [15:0] mm [16];
  logic [15:0] m_wf = '0, m_rf = '0, m_nc = '0, m_p2 = '0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_step(input bit en, input bit we, input logic [3:0] a, input logic [15:0] d);
    logic [15:0] old;
    old = mm[a];
    if (en && we) mm[a] = d;
    if (!rsta_n) begin
      m_wf = '0; m_rf = '0; m_nc = '0; m_p2 = '0;
    end else begin
      m_p2 = m_wf;
      if (en) begin
        if (!we) begin
          m_wf = old; m_rf = old; m_nc = old;
        end else begin
          m_wf = d; m_rf = old;
        end
      end
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.wf = m_wf; e.rf = m_rf; e.nc = m_nc; e.p2 = m_p2;
    sbq.push_back(e);
  endtask

  // Drive one cycle; called at a falling edge, returns at the next falling edge.
  task automatic op(input bit en, input bit we, input logic [3:0] a, input logic [15:0] d,
                    input string tag);
    ena = en; wea = we; addra = a; dina = d;
    model_step(en, we, a, d);
    @(posedge clk);
    push_exp(tag);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.tag, "/wf"}, dout_wf, e.wf);
      chk({e.tag, "/rf"}, dout_rf, e.rf);
      chk({e.tag, "/nc"}, dout_nc, e.nc);
      chk({e.tag, "/p2"}, dout_p2, e.p2);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mm[i] = '0;

    // Reset state
    #1 rsta_n = 1'b0;
    #2;
    chk("rst_wf", dout_wf, 16'h0000);
    chk("rst_rf", dout_rf, 16'h0000);
    chk("rst_nc", dout_nc, 16'h0000);
    chk("rst_p2", dout_p2, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rsta_n = 1'b1;
    for (int i = 0; i < 3; i++) op(1'b0, 1'b0, 4'd0, 16'h0, "sync");

    // Initial contents before any write
    op(1'b1, 1'b0, 4'd2, 16'h0, "init_rd");
    op(1'b0, 1'b0, 4'd0, 16'h0, "init_flush");

    // Fill, with ena dropped (and junk on the other inputs) between writes
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 1'b1, 4'(i), 16'h1000 + 16'(i), "fill");
      op(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), "fill_gap");
    end
    for (int i = 0; i < 20; i++) op(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), "idle");

    // Back-to-back readback
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 4'(i), 16'($urandom), "readback");

    // Write-mode behaviour on a write cycle
    op(1'b1, 1'b0, 4'd0, 16'h0, "pre_wm");
    op(1'b1, 1'b1, 4'd3, 16'hBEEF, "wmode");
    op(1'b1, 1'b0, 4'd3, 16'h0, "wm_rd");

    // Enable gating
    for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 4'd5, 16'hFFFF, "gate");
    op(1'b1, 1'b0, 4'd5, 16'h0, "gate_rd");

    // Async reset mid-cycle during a read stream
    op(1'b1, 1'b0, 4'd0, 16'h0, "strm");
    op(1'b1, 1'b0, 4'd1, 16'h0, "strm");
    op(1'b1, 1'b0, 4'd2, 16'h0, "strm");
    ena = 1'b1; wea = 1'b0; addra = 4'd4;
    model_step(1'b1, 1'b0, 4'd4, 16'h0);
    @(posedge clk);
    #2 rsta_n = 1'b0;
    m_wf = '0; m_rf = '0; m_nc = '0; m_p2 = '0;
    #1;
    chk("arst_wf", dout_wf, 16'h0000);
    chk("arst_rf", dout_rf, 16'h0000);
    chk("arst_nc", dout_nc, 16'h0000);
    chk("arst_p2", dout_p2, 16'h0000);
    push_exp("arst");
    @(negedge clk);
    op(1'b1, 1'b1, 4'd12, 16'h2222, "rst_wr");
    op(1'b1, 1'b0, 4'd6, 16'h0, "rst_rd");
    rsta_n = 1'b1;
    for (int i = 0; i < 3; i++) op(1'b0, 1'b0, 4'd0, 16'h0, "rel");
    op(1'b1, 1'b0, 4'd7, 16'h0, "post_rst7");
    op(1'b1, 1'b0, 4'd12, 16'h0, "post_rst12");

    // Two-stage latency and streaming
    op(1'b0, 1'b0, 4'd0, 16'h0, "lat_gap");
    for (int i = 9; i < 14; i++) op(1'b1, 1'b0, 4'(i), 16'h0, "stream2");
    op(1'b0, 1'b0, 4'd0, 16'h0, "drain");
    op(1'b0, 1'b0, 4'd0, 16'h0, "drain");

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
